chip8_alu_pipe: RTL and testbench

- Parametrised, registered successor to the CHIP-8 combinational ALU.
- Accepts one operation per handshake and returns a registered result plus a VF flag.
- Adds a multi-cycle BCD conversion (for FX33) using a shift-add-3 sequencer.
- Sits between the CPU decode stage and the register-file writeback, with valid/ready on both sides so the CPU can stall.

---
 rtl/chip8_alu_pkg.sv | 25 ++
 rtl/chip8_bcd_step.sv | 30 +++
 rtl/chip8_alu_pipe.sv | 187 ++++++++++++++++++
 tb/tb_chip8_alu_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_alu_pkg.sv
// Shared types for the CHIP-8 pipelined ALU: opcodes and sequencer states.
package chip8_alu_pkg;

    typedef enum logic [3:0] {
        OP_OR   = 4'd0,
        OP_AND  = 4'd1,
        OP_XOR  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_SUBN = 4'd5,
        OP_SHR  = 4'd6,
        OP_SHL  = 4'd7,
        OP_EQ   = 4'd8,
        OP_GT   = 4'd9,
        OP_INC  = 4'd10,
        OP_BCD  = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BCD_RUN  = 2'd1,
        BCD_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/chip8_bcd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the whole {bcd, binary} register left by one bit.
module chip8_bcd_step #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS+WIDTH-1:0] sh_in,
    output logic [4*DIGITS+WIDTH-1:0] sh_out
);

    localparam int SH_W = 4 * DIGITS + WIDTH;

    logic [SH_W-1:0] adj;
    logic [3:0]      nib;

    // Correct each BCD digit so the following shift carries cleanly into the next digit.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
        adj = sh_in;
        nib = '0;
        for (int d = 0; d < DIGITS; d++) begin
            nib = sh_in[WIDTH + 4*d +: 4];
            if (nib >= 4'd5) begin
                adj[WIDTH + 4*d +: 4] = nib + 4'd3;
            end
        end
        sh_out = {adj[SH_W-2:0], 1'b0};
    end

endmodule

// File: rtl/chip8_alu_pipe.sv
// Registered CHIP-8 ALU with valid/ready on both sides and a multi-cycle
// binary-to-BCD sequencer for FX33.
module chip8_alu_pipe
    import chip8_alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic                  out_flag,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy
);

    // Counter width is derived from WIDTH and intentionally not overridable.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + WIDTH;

    alu_state_t        state_q, state_d;
    logic              active_q, active_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_result_q, out_result_d;
    logic              out_flag_q, out_flag_d;
    logic [BCD_W-1:0]  out_bcd_q, out_bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]  opa_q, opa_d;

    logic [SH_W-1:0]   step_out;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_flag;
    logic [WIDTH:0]    alu_wide;
    logic              accept;

    chip8_bcd_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bcd_step (
        .sh_in  (shreg_q),
        .sh_out (step_out)
    );

    // active_q holds in_ready low until the first clock after reset release.
    assign in_ready   = active_q && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q == BCD_RUN);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flag   = out_flag_q;
    assign out_bcd    = out_bcd_q;

    // Single-cycle ALU datapath; carry/borrow come from the extra top bit of a WIDTH+1 computation.
    always_comb begin
        alu_result = '0;
        alu_flag   = 1'b0;
        alu_wide   = '0;
        case (alu_op_t'(in_op))
            OP_OR:   alu_result = in_a | in_b;
            OP_AND:  alu_result = in_a & in_b;
            OP_XOR:  alu_result = in_a ^ in_b;
            OP_ADD: begin
                alu_wide   = {1'b0, in_a} + {1'b0, in_b};
                alu_result = alu_wide[WIDTH-1:0];
                alu_flag   = alu_wide[WIDTH];
            end
            OP_SUB: begin
                alu_wide   = {1'b0, in_a} - {1'b0, in_b};
                alu_result = alu_wide[WIDTH-1:0];
                alu_flag   = ~alu_wide[WIDTH];
            end
            OP_SUBN: begin
                alu_wide   = {1'b0, in_b} - {1'b0, in_a};
                alu_result = alu_wide[WIDTH-1:0];
                alu_flag   = ~alu_wide[WIDTH];
            end
            OP_SHR: begin
                alu_result = in_a >> 1;
                alu_flag   = in_a[0];
            end
            OP_SHL: begin
                alu_result = {in_a[WIDTH-2:0], 1'b0};
                alu_flag   = in_a[WIDTH-1];
            end
            OP_EQ:   alu_result = WIDTH'(in_a == in_b);
            OP_GT:   alu_result = WIDTH'(in_a > in_b);
            OP_INC: begin
                alu_wide   = {1'b0, in_a} + (WIDTH+1)'(1);
                alu_result = alu_wide[WIDTH-1:0];
                alu_flag   = alu_wide[WIDTH];
            end
            default: begin
                alu_result = '0;
                alu_flag   = 1'b0;
            end
        endcase
    end

    // Next-state logic for the sequencer and the output holding registers.
    always_comb begin
        state_d      = state_q;
        active_d     = 1'b1;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flag_d   = out_flag_q;
        out_bcd_d    = out_bcd_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        opa_d        = opa_q;

        // Draining the current result; a load below in the same cycle overrides this.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (alu_op_t'(in_op) == OP_BCD) begin
                        state_d = BCD_RUN;
                        shreg_d = {{BCD_W{1'b0}}, in_a};
                        cnt_d   = CNT_W'(WIDTH);
                        opa_d   = in_a;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_result_d = alu_result;
                        out_flag_d   = alu_flag;
                        out_bcd_d    = '0;
                    end
                end
            end
            BCD_RUN: begin
                shreg_d = step_out;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = BCD_DONE;
                end
            end
            BCD_DONE: begin
                if (!out_valid_q || out_ready) begin
                    out_valid_d  = 1'b1;
                    out_result_d = opa_q;
                    out_flag_d   = 1'b0;
                    out_bcd_d    = shreg_q[SH_W-1 -: BCD_W];
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any conversion in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            active_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flag_q   <= 1'b0;
            out_bcd_q    <= '0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            opa_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            active_q     <= active_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flag_q   <= out_flag_d;
            out_bcd_q    <= out_bcd_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            opa_q        <= opa_d;
        end
    end

endmodule

// File: tb/tb_chip8_alu_pipe.sv
// Self-checking bench for chip8_alu_pipe (WIDTH=8, DIGITS=3).
module tb_chip8_alu_pipe;
    import chip8_alu_pkg::*;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_result;
    logic        out_flag;
    logic [11:0] out_bcd;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        alu_op_t    op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       f;
    } vec_t;

    typedef struct {
        int r;
        int f;
        int bcd;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];

    chip8_alu_pipe dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flag   (out_flag),
        .out_bcd    (out_bcd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definition of each operation.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   m;
        m = 1 << W;
        e.r = 0; e.f = 0; e.bcd = 0;
        case (op)
            0:  e.r = a | b;
            1:  e.r = a & b;
            2:  e.r = a ^ b;
            3:  begin e.r = (a + b) % m; e.f = (a + b >= m) ? 1 : 0; end
            4:  begin e.r = (a - b + m) % m; e.f = (a >= b) ? 1 : 0; end
            5:  begin e.r = (b - a + m) % m; e.f = (b >= a) ? 1 : 0; end
            6:  begin e.r = a / 2; e.f = a % 2; end
            7:  begin e.r = (a * 2) % m; e.f = (a >= m / 2) ? 1 : 0; end
            8:  e.r = (a == b) ? 1 : 0;
            9:  e.r = (a > b) ? 1 : 0;
            10: begin e.r = (a + 1) % m; e.f = (a == m - 1) ? 1 : 0; end
            11: begin e.r = a; e.bcd = (a / 100) * 256 + ((a / 10) % 10) * 16 + (a % 10); end
            default: ;
        endcase
        return e;
    endfunction

    task automatic run_single(input vec_t v, input string tag);
        @(negedge clk);
        in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b; out_ready = 1'b1;
        #1;
        check({tag, "_ready"}, int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_result"}, int'(out_result), int'(v.r));
        check({tag, "_flag"}, int'(out_flag), int'(v.f));
        check({tag, "_bcd"}, int'(out_bcd), 0);
    endtask

    task automatic run_bcd(input logic [7:0] a, input int exp_bcd, input string tag);
        int lat;
        int busy_cnt;
        int rdy_hi;
        lat = -1; busy_cnt = 0; rdy_hi = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_BCD; in_a = a; in_b = 8'h00; out_ready = 1'b1;
        #1;
        check({tag, "_accept"}, int'(in_ready), 1);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            // Keep requesting a different op with different data: it must be ignored.
            if (k == 1) begin in_op = OP_ADD; in_a = ~a; end
            #1;
            if (out_valid) begin lat = k - 1; break; end
            if (busy) busy_cnt++;
            if (in_ready) rdy_hi++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, lat, 9);
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_ready_low"}, rdy_hi, 0);
        check({tag, "_bcd"}, int'(out_bcd), exp_bcd);
        check({tag, "_result"}, int'(out_result), int'(a));
        check({tag, "_flag"}, int'(out_flag), 0);
    endtask

    initial begin
        exp_t       e[4];
        exp_t       got;
        logic [7:0] held_r;
        logic       held_f;
        logic [11:0] held_bcd;
        bit         prev_stall;
        int         seen;

        vecs[0]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[1]  = '{OP_ADD,  8'h12, 8'h34, 8'h46, 1'b0};
        vecs[2]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 1'b1};
        vecs[3]  = '{OP_SUB,  8'h03, 8'h05, 8'hFE, 1'b0};
        vecs[4]  = '{OP_SUBN, 8'h03, 8'h05, 8'h02, 1'b1};
        vecs[5]  = '{OP_SHL,  8'h81, 8'h00, 8'h02, 1'b1};
        vecs[6]  = '{OP_SHR,  8'h81, 8'h00, 8'h40, 1'b1};
        vecs[7]  = '{OP_OR,   8'hF0, 8'h0F, 8'hFF, 1'b0};
        vecs[8]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[9]  = '{OP_XOR,  8'hAA, 8'h0F, 8'hA5, 1'b0};
        vecs[10] = '{OP_EQ,   8'h5A, 8'h5A, 8'h01, 1'b0};
        vecs[11] = '{OP_EQ,   8'h5A, 8'h5B, 8'h00, 1'b0};
        vecs[12] = '{OP_GT,   8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[13] = '{OP_GT,   8'h7F, 8'h80, 8'h00, 1'b0};
        vecs[14] = '{OP_INC,  8'hFF, 8'h00, 8'h00, 1'b1};
        vecs[15] = '{OP_INC,  8'h7F, 8'h00, 8'h80, 1'b0};
        vecs[16] = '{alu_op_t'(4'd13), 8'h12, 8'h34, 8'h00, 1'b0};

        // Reset with a pending request: nothing may be accepted or produced.
        reset_n = 1'b0; in_valid = 1'b1; in_op = OP_ADD; in_a = 8'h01; in_b = 8'h02; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_ready", int'(in_ready), 0);
        check("rst_result", int'(out_result), 0);
        check("rst_flag", int'(out_flag), 0);
        check("rst_bcd", int'(out_bcd), 0);
        check("rst_busy", int'(busy), 0);
        reset_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("rst_release_ready", int'(in_ready), 1);
        check("rst_release_valid", int'(out_valid), 0);

        // Directed single-cycle vectors.
        for (int i = 0; i < 17; i++) begin
            run_single(vecs[i], $sformatf("vec%0d", i));
        end

        // BCD conversions.
        run_bcd(8'hFE, 12'h254, "bcd_254");
        run_bcd(8'h00, 12'h000, "bcd_0");
        run_bcd(8'hFF, 12'h255, "bcd_255");

        // Backpressure: drain, then hold an ADD result with out_ready low.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_ADD; in_a = 8'h12; in_b = 8'h34; out_ready = 1'b0;
        @(negedge clk);
        in_op = OP_SUB; in_a = 8'h99; in_b = 8'h11;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_valid", int'(out_valid), 1);
            check("stall_result", int'(out_result), 8'h46);
            check("stall_flag", int'(out_flag), 0);
            check("stall_ready", int'(in_ready), 0);
            @(negedge clk);
        end

        // Release with a back-to-back stream of XORs: drain-and-accept each cycle.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1; in_op = OP_XOR;
            in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255));
            e[i] = model(2, int'(in_a), int'(in_b));
            #1;
            check($sformatf("stream_ready%0d", i), int'(in_ready), 1);
            check($sformatf("stream_prev_valid%0d", i), int'(out_valid), 1);
            if (i == 0) check("stream_drain_add", int'(out_result), 8'h46);
            else check($sformatf("stream_result%0d", i - 1), int'(out_result), e[i-1].r);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("stream_last_valid", int'(out_valid), 1);
        check("stream_result3", int'(out_result), e[3].r);
        @(negedge clk);
        check("stream_no_dup", int'(out_valid), 0);

        // Randomised traffic against the scoreboard.
        prev_stall = 1'b0; held_r = '0; held_f = 1'b0; held_bcd = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 4'($urandom_range(0, 15));
            in_a      = 8'($urandom_range(0, 255));
            in_b      = ($urandom_range(0, 7) == 0) ? in_a : 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                check("rnd_hold_valid", int'(out_valid), 1);
                check("rnd_hold_result", int'(out_result), int'(held_r));
                check("rnd_hold_flag", int'(out_flag), int'(held_f));
                check("rnd_hold_bcd", int'(out_bcd), int'(held_bcd));
            end
            if (out_valid && out_ready) begin
                check("rnd_sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check("rnd_result", int'(out_result), got.r);
                    check("rnd_flag", int'(out_flag), got.f);
                    check("rnd_bcd", int'(out_bcd), got.bcd);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(int'(in_op), int'(in_a), int'(in_b)));
            end
            prev_stall = out_valid && !out_ready;
            held_r = out_result; held_f = out_flag; held_bcd = out_bcd;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                got = sb.pop_front();
                check("drain_result", int'(out_result), got.r);
                check("drain_flag", int'(out_flag), got.f);
                check("drain_bcd", int'(out_bcd), got.bcd);
            end
            @(negedge clk);
        end
        check("drain_empty", sb.size(), 0);

        // Reset in the 4th BCD cycle aborts the conversion.
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_BCD; in_a = 8'h99; in_b = 8'h00; out_ready = 1'b1;
        #1;
        check("abort_accept", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(in_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        check("abort_idle_ready", int'(in_ready), 1);
        run_single('{OP_INC, 8'hFF, 8'h00, 8'h00, 1'b1}, "abort_inc");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
